dds_param_ctrl: RTL
===================

DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

Interface
REQ-001 The block SHALL have parameter FWORD_W, default 32, meaning frequency tuning word width.
REQ-002 The block SHALL have parameter PWORD_W, default 12, meaning phase offset word width.
REQ-003 The block SHALL have parameter AMP_W, default 8, meaning amplitude scale width.
REQ-004 The block SHALL have parameter FSTEP_UNIT, default 43, meaning the tuning-word increment for step index 0.
REQ-005 The block SHALL have parameter FWORD_MAX, default 32'h7FFF_FFFF, meaning the frequency saturation ceiling.
REQ-006 The block SHALL have parameters FWORD_DEF, PWORD_DEF, AMP_DEF, defaults 4300, 0, 255, meaning the power-up values.
REQ-007 Ports SHALL be: clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 k0..k5  in  1 each  one-cycle key pulses: k0 select, k1 inc, k2 dec, k3 step, k4 default, k5 commit.
REQ-010 fword  out  FWORD_W  committed frequency word; pword  out  PWORD_W  committed phase; amp  out  AMP_W  committed amplitude; wave  out  2  committed waveform.
REQ-011 sel  out  2  edited field (0 FREQ, 1 PHASE, 2 AMP, 3 WAVE); step_idx  out  2  current step index.
REQ-012 update  out  1  one-cycle strobe when committed outputs change; dirty  out  1  shadow differs from committed.

Function
REQ-013 Shadow registers for all four fields SHALL be edited; committed outputs SHALL change only on commit.
REQ-014 Edits SHALL be visible in shadow one cycle after the pulse; committed outputs and update SHALL change one cycle after k5.
REQ-015 sel SHALL be a 4-state machine FREQ->PHASE->AMP->WAVE->FREQ, advancing on k0.
REQ-016 step_idx SHALL advance 0->1->2->3->0 on k3 and SHALL reset to 0 on every sel change.
REQ-017 FREQ step SHALL be FSTEP_UNIT x {1,10,100,1000}; PHASE step {1,8,64,512}; AMP step {1,4,16,64}; WAVE step always 1.
REQ-018 FREQ inc/dec SHALL saturate at FWORD_MAX and 0; overflow-free arithmetic one bit wider than the field.
REQ-019 PHASE inc/dec SHALL wrap modulo 2^PWORD_W.
REQ-020 AMP inc/dec SHALL saturate at 2^AMP_W-1 and 0.
REQ-021 WAVE inc/dec SHALL wrap modulo 4.
REQ-022 k4 SHALL load the selected shadow field with its default (WAVE default 0).
REQ-023 Same-cycle priority SHALL be k4 > k0 > k3 > k1/k2; k1 and k2 together SHALL be ignored.
REQ-024 k5 SHALL commit the shadow values held before that cycle's edit; a same-cycle edit lands in shadow only.
REQ-025 update SHALL pulse on every k5, even if values are unchanged.
REQ-026 dirty SHALL be registered and equal (shadow != committed) for all fields, evaluated on post-cycle values.

Reset
REQ-027 On rst, shadow and committed fields SHALL load FWORD_DEF, PWORD_DEF, AMP_DEF, wave 0.
REQ-028 On rst, sel SHALL be FREQ, step_idx 0, update 0, dirty 0.
REQ-029 rst SHALL override all key pulses in the same cycle; a pending edit or commit is discarded.

Structure
REQ-030 Package dds_ctrl_pkg SHALL hold the sel encoding, the step tables, and the field widths.
REQ-031 Saturating add/sub SHALL be one sub-module, sat_addsub, parameterised by width, ceiling, and wrap/saturate mode; instantiated per field.

Verification
REQ-032 rst, then k1 x3 at sel FREQ, step 0 -> shadow fword 4429, fword stays 4300, dirty 1; k5 -> fword 4429, update 1 cycle, dirty 0.
REQ-033 AMP: k2 x5 at step 3 from 255 -> shadow sequence 191, 127, 63, 0, 0.
REQ-034 PHASE: step 3, k1 x8 from 0 -> 512, 1024, ..., 3584, 0 (wrap).
REQ-035 k1 and k2 same cycle -> no change; k0 and k3 same cycle -> sel advances, step_idx 0.
REQ-036 k5 with k1 same cycle at FREQ -> fword gets pre-edit value, shadow +43, dirty stays 1.
REQ-037 rst asserted the same cycle as k5 -> all outputs at defaults, update 0.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
//------------------------------------------------------------------------------
// dds_ctrl_pkg
//
// Shared definitions for the DDS parameter controller:
//   - default field widths for the frequency, phase and amplitude words
//   - the field-select encoding used by the editor state machine
//   - the per-field step multiplier tables, indexed by the step index
//   - small helpers to look up a step multiplier and to advance the selection
//------------------------------------------------------------------------------
package dds_ctrl_pkg;

    // Default widths of the editable fields
    localparam int FWORD_W_DEF = 32;
    localparam int PWORD_W_DEF = 12;
    localparam int AMP_W_DEF   = 8;
    localparam int WAVE_W      = 2;
    localparam int SEL_W       = 2;
    localparam int STEP_W      = 2;

    // Field currently being edited; the order is also the k0 rotation order
    typedef enum logic [SEL_W-1:0] {
        SEL_FREQ  = 2'd0,
        SEL_PHASE = 2'd1,
        SEL_AMP   = 2'd2,
        SEL_WAVE  = 2'd3
    } sel_e;

    // Step multipliers per field, indexed by step_idx.
    // The frequency table is further scaled by FSTEP_UNIT in the top level.
    localparam int unsigned FREQ_MULT  [4] = '{1, 10, 100, 1000};
    localparam int unsigned PHASE_MULT [4] = '{1, 8, 64, 512};
    localparam int unsigned AMP_MULT   [4] = '{1, 4, 16, 64};

    // Multiplier for a given field and step index (waveform always steps by 1)
    function automatic int unsigned step_mult(input sel_e field,
                                              input logic [STEP_W-1:0] idx);
        int unsigned m;
        m = 1;
        case (field)
            SEL_FREQ:  m = FREQ_MULT[idx];
            SEL_PHASE: m = PHASE_MULT[idx];
            SEL_AMP:   m = AMP_MULT[idx];
            SEL_WAVE:  m = 1;
            default:   m = 1;
        endcase
        return m;
    endfunction

    // Rotate FREQ -> PHASE -> AMP -> WAVE -> FREQ
    function automatic sel_e next_sel(input sel_e cur);
        logic [SEL_W-1:0] nxt;
        nxt = cur + 2'd1;
        return sel_e'(nxt);
    endfunction

endpackage

// File: rtl/sat_addsub.sv
//------------------------------------------------------------------------------
// sat_addsub
//
// Combinational add/subtract of a step to a field value, either wrapping
// modulo 2^W or saturating at [0, CEIL].
//
// Parameters:
//   W     - field width
//   CEIL  - saturation ceiling (ignored when WRAP is set)
//   WRAP  - 1: modular arithmetic, 0: saturating arithmetic
//
// Ports:
//   value  - current field value
//   step   - amount to add or subtract
//   inc    - add step
//   dec    - subtract step
//   result - updated value; equals value when neither or both of inc/dec set
//------------------------------------------------------------------------------
module sat_addsub #(
    parameter int           W    = 8,
    parameter logic [W-1:0] CEIL = '1,
    parameter bit           WRAP = 1'b0
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] step,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] result
);

    logic [W:0] sum;
    logic [W:0] diff;

    // One extra bit holds the carry of the add and the borrow of the subtract,
    // so overflow and underflow are detected without wrapping first.
    always_comb begin
        sum    = {1'b0, value} + {1'b0, step};
        diff   = {1'b0, value} - {1'b0, step};
        result = value;
        if (inc && !dec) begin
            if (WRAP) begin
                result = sum[W-1:0];
            end else if (sum > {1'b0, CEIL}) begin
                result = CEIL;
            end else begin
                result = sum[W-1:0];
            end
        end else if (dec && !inc) begin
            if (WRAP) begin
                result = diff[W-1:0];
            end else if (diff[W]) begin
                result = '0;
            end else begin
                result = diff[W-1:0];
            end
        end
    end

endmodule

// File: rtl/dds_param_ctrl.sv
//------------------------------------------------------------------------------
// dds_param_ctrl
//
// Key-driven editor for DDS parameters. Four shadow fields (frequency word,
// phase offset, amplitude, waveform) are edited with one-cycle key pulses and
// copied to the committed outputs on a commit key.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   k0        - select next field
//   k1 / k2   - increment / decrement selected shadow field by current step
//   k3        - advance step index
//   k4        - load selected shadow field with its default
//   k5        - commit shadow fields to the outputs
//   fword     - committed frequency tuning word
//   pword     - committed phase offset
//   amp       - committed amplitude scale
//   wave      - committed waveform
//   sel       - field being edited (0 FREQ, 1 PHASE, 2 AMP, 3 WAVE)
//   step_idx  - current step index
//   update    - one-cycle strobe following every commit
//   dirty     - shadow fields differ from committed fields
//------------------------------------------------------------------------------
module dds_param_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int                 FWORD_W    = FWORD_W_DEF,
    parameter int                 PWORD_W    = PWORD_W_DEF,
    parameter int                 AMP_W      = AMP_W_DEF,
    parameter int unsigned        FSTEP_UNIT = 43,
    parameter logic [FWORD_W-1:0] FWORD_MAX  = 32'h7FFF_FFFF,
    parameter logic [FWORD_W-1:0] FWORD_DEF  = 32'd4300,
    parameter logic [PWORD_W-1:0] PWORD_DEF  = '0,
    parameter logic [AMP_W-1:0]   AMP_DEF    = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               k0,
    input  logic               k1,
    input  logic               k2,
    input  logic               k3,
    input  logic               k4,
    input  logic               k5,
    output logic [FWORD_W-1:0] fword,
    output logic [PWORD_W-1:0] pword,
    output logic [AMP_W-1:0]   amp,
    output logic [WAVE_W-1:0]  wave,
    output logic [SEL_W-1:0]   sel,
    output logic [STEP_W-1:0]  step_idx,
    output logic               update,
    output logic               dirty
);

    localparam logic [AMP_W-1:0]  AMP_MAX  = '1;
    localparam logic [WAVE_W-1:0] WAVE_DEF = '0;

    // Editor state
    sel_e               sel_q;
    logic [FWORD_W-1:0] sh_fword;
    logic [PWORD_W-1:0] sh_pword;
    logic [AMP_W-1:0]   sh_amp;
    logic [WAVE_W-1:0]  sh_wave;

    // Next-state values
    sel_e               sel_nxt;
    logic [STEP_W-1:0]  step_nxt;
    logic [FWORD_W-1:0] sh_fword_nxt;
    logic [PWORD_W-1:0] sh_pword_nxt;
    logic [AMP_W-1:0]   sh_amp_nxt;
    logic [WAVE_W-1:0]  sh_wave_nxt;
    logic [FWORD_W-1:0] fword_nxt;
    logic [PWORD_W-1:0] pword_nxt;
    logic [AMP_W-1:0]   amp_nxt;
    logic [WAVE_W-1:0]  wave_nxt;
    logic               dirty_nxt;

    // Step sizes for the current step index
    logic [63:0]        freq_step_wide;
    int unsigned        amp_mult;
    logic [FWORD_W-1:0] freq_step;
    logic [PWORD_W-1:0] phase_step;
    logic [AMP_W-1:0]   amp_step;
    logic [WAVE_W-1:0]  wave_step;

    // Candidate edited values from the arithmetic units
    logic [FWORD_W-1:0] freq_res;
    logic [PWORD_W-1:0] phase_res;
    logic [AMP_W-1:0]   amp_res;
    logic [WAVE_W-1:0]  wave_res;

    assign sel = sel_q;

    // Step sizes per field. Saturating fields clamp an oversized step to the
    // ceiling, which gives the same result as applying the full step. The
    // phase step may simply be truncated because that field wraps anyway.
    always_comb begin
        freq_step_wide = 64'(FSTEP_UNIT) * 64'(step_mult(SEL_FREQ, step_idx));
        if (freq_step_wide > 64'(FWORD_MAX)) begin
            freq_step = FWORD_MAX;
        end else begin
            freq_step = FWORD_W'(freq_step_wide);
        end

        phase_step = PWORD_W'(step_mult(SEL_PHASE, step_idx));

        amp_mult = step_mult(SEL_AMP, step_idx);
        if (amp_mult > 32'(AMP_MAX)) begin
            amp_step = AMP_MAX;
        end else begin
            amp_step = AMP_W'(amp_mult);
        end

        wave_step = WAVE_W'(1);
    end

    // One arithmetic unit per field; k1 and k2 together leave the value as-is
    sat_addsub #(.W(FWORD_W), .CEIL(FWORD_MAX), .WRAP(1'b0)) u_freq (
        .value  (sh_fword),
        .step   (freq_step),
        .inc    (k1),
        .dec    (k2),
        .result (freq_res)
    );

    sat_addsub #(.W(PWORD_W), .CEIL('1), .WRAP(1'b1)) u_phase (
        .value  (sh_pword),
        .step   (phase_step),
        .inc    (k1),
        .dec    (k2),
        .result (phase_res)
    );

    sat_addsub #(.W(AMP_W), .CEIL(AMP_MAX), .WRAP(1'b0)) u_amp (
        .value  (sh_amp),
        .step   (amp_step),
        .inc    (k1),
        .dec    (k2),
        .result (amp_res)
    );

    sat_addsub #(.W(WAVE_W), .CEIL('1), .WRAP(1'b1)) u_wave (
        .value  (sh_wave),
        .step   (wave_step),
        .inc    (k1),
        .dec    (k2),
        .result (wave_res)
    );

    // Key decode. Only one edit action happens per cycle, in the order
    // default > select > step > inc/dec. Commit runs alongside and always
    // copies the shadow values from before this cycle's edit.
    always_comb begin
        sel_nxt      = sel_q;
        step_nxt     = step_idx;
        sh_fword_nxt = sh_fword;
        sh_pword_nxt = sh_pword;
        sh_amp_nxt   = sh_amp;
        sh_wave_nxt  = sh_wave;
        fword_nxt    = fword;
        pword_nxt    = pword;
        amp_nxt      = amp;
        wave_nxt     = wave;

        if (k4) begin
            case (sel_q)
                SEL_FREQ:  sh_fword_nxt = FWORD_DEF;
                SEL_PHASE: sh_pword_nxt = PWORD_DEF;
                SEL_AMP:   sh_amp_nxt   = AMP_DEF;
                SEL_WAVE:  sh_wave_nxt  = WAVE_DEF;
                default:   sh_wave_nxt  = sh_wave;
            endcase
        end else if (k0) begin
            sel_nxt  = next_sel(sel_q);
            step_nxt = '0;
        end else if (k3) begin
            step_nxt = step_idx + STEP_W'(1);
        end else if (k1 != k2) begin
            case (sel_q)
                SEL_FREQ:  sh_fword_nxt = freq_res;
                SEL_PHASE: sh_pword_nxt = phase_res;
                SEL_AMP:   sh_amp_nxt   = amp_res;
                SEL_WAVE:  sh_wave_nxt  = wave_res;
                default:   sh_wave_nxt  = sh_wave;
            endcase
        end

        if (k5) begin
            fword_nxt = sh_fword;
            pword_nxt = sh_pword;
            amp_nxt   = sh_amp;
            wave_nxt  = sh_wave;
        end

        dirty_nxt = (sh_fword_nxt != fword_nxt) ||
                    (sh_pword_nxt != pword_nxt) ||
                    (sh_amp_nxt   != amp_nxt)   ||
                    (sh_wave_nxt  != wave_nxt);
    end

    // State registers; reset discards any edit or commit in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= SEL_FREQ;
            step_idx <= '0;
            sh_fword <= FWORD_DEF;
            sh_pword <= PWORD_DEF;
            sh_amp   <= AMP_DEF;
            sh_wave  <= WAVE_DEF;
            fword    <= FWORD_DEF;
            pword    <= PWORD_DEF;
            amp      <= AMP_DEF;
            wave     <= WAVE_DEF;
            update   <= 1'b0;
            dirty    <= 1'b0;
        end else begin
            sel_q    <= sel_nxt;
            step_idx <= step_nxt;
            sh_fword <= sh_fword_nxt;
            sh_pword <= sh_pword_nxt;
            sh_amp   <= sh_amp_nxt;
            sh_wave  <= sh_wave_nxt;
            fword    <= fword_nxt;
            pword    <= pword_nxt;
            amp      <= amp_nxt;
            wave     <= wave_nxt;
            update   <= k5;
            dirty    <= dirty_nxt;
        end
    end

endmodule
